// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with epoch echo (mailbox enabled by DMEM_TOHOST_EN)
module dmem_responder #(
  parameter int          DEPTH_WORDS  = 1024,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] TOHOST_ADDR  = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_epoch,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  rsp_epoch
`ifdef DMEM_TOHOST_EN
  ,
  output logic        tohost_valid,
  output logic [31:0] tohost_data
`endif
);

  localparam logic [1:0] MEM_READ      = 2'd1;
  localparam logic [1:0] MEM_WRITE     = 2'd2;
  localparam logic [1:0] EPOCH_INVALID = 2'd0;
  localparam int         AW            = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [1:0]  epoch_q, epoch_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept, is_rd, is_wr, misaligned, out_of_range, tohost_hit, req_err, mem_we;
  logic [AW-1:0] widx;
  logic [31:0]   ram_word;

`ifdef DMEM_TOHOST_EN
  logic        tohost_valid_q, tohost_valid_d;
  logic [31:0] tohost_data_q, tohost_data_d;
  assign tohost_hit   = (req_addr == TOHOST_ADDR);
  assign tohost_valid = tohost_valid_q;
  assign tohost_data  = tohost_data_q;
`else
  // The mailbox address has no role when the mailbox is compiled out
  logic unused_tohost;
  assign unused_tohost = ^TOHOST_ADDR;
  assign tohost_hit    = 1'b0;
`endif

  assign accept       = req_valid & req_ready;
  assign is_rd        = (req_op == MEM_READ);
  assign is_wr        = (req_op == MEM_WRITE);
  assign misaligned   = |req_addr[1:0];
  assign out_of_range = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign req_err      = misaligned | (out_of_range & ~tohost_hit) | ~(is_rd | is_wr);
  assign widx         = req_addr[AW+1:2];
  assign ram_word     = mem_q[widx];
  assign mem_we       = accept & is_wr & ~req_err & ~tohost_hit;

  // Ready only after the first post-reset edge, and only while idle
  assign req_ready = ready_q & (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign rsp_epoch = epoch_q;

  // Next-state and captured-response logic; read data is sampled at accept so later writes cannot leak in
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = 1'b1;
    rdata_d = rdata_q;
    err_d   = err_q;
    epoch_d = epoch_q;
`ifdef DMEM_TOHOST_EN
    tohost_valid_d = 1'b0;
    tohost_data_d  = tohost_data_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          epoch_d = req_epoch;
          err_d   = req_err;
          rdata_d = (is_rd & ~req_err & ~tohost_hit) ? ram_word : 32'h0;
          if (is_rd & ~req_err & (READ_LATENCY > 1)) begin
            state_d = S_WAIT;
            cnt_d   = 3'(READ_LATENCY - 1);
          end else begin
            state_d = S_RESP;
          end
`ifdef DMEM_TOHOST_EN
          if (is_wr & tohost_hit) begin
            tohost_valid_d = 1'b1;
            tohost_data_d  = req_wdata;
          end
`endif
        end
      end
      S_WAIT: begin
        if (cnt_q <= 3'd1) state_d = S_RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers; reset drops any in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      epoch_q <= EPOCH_INVALID;
`ifdef DMEM_TOHOST_EN
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= 32'h0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      epoch_q <= epoch_d;
`ifdef DMEM_TOHOST_EN
      tohost_valid_q <= tohost_valid_d;
      tohost_data_q  <= tohost_data_d;
`endif
    end
  end

  // Word RAM, written on the accept edge and never cleared by reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[widx] <= req_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder (two latencies, optional DMEM_TOHOST_EN)
module tb_dmem_responder;

  localparam int          DEPTH  = 64;
  localparam int          LAT0   = 3;
  localparam int          LAT1   = 1;
  localparam logic [31:0] TOHOST = 32'hFFFF_FFF0;
  localparam logic [1:0]  OP_INV = 2'd0, OP_RD = 2'd1, OP_WR = 2'd2;
  localparam logic [1:0]  EP_INV = 2'd0, EP_RED = 2'd1, EP_BLUE = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        rsp_ready_drv = 1'b0;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [1:0]  req_epoch = 2'd0;
  int          sel = 0;

  int errors = 0;
  int checks = 0;

  logic        v0, v1, rr0, rr1;
  logic        q0_ready, q0_valid, q0_err, q1_ready, q1_valid, q1_err;
  logic [31:0] q0_rdata, q1_rdata;
  logic [1:0]  q0_epoch, q1_epoch;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_epoch;
`ifdef DMEM_TOHOST_EN
  logic        t0_valid, t1_valid, th_valid;
  logic [31:0] t0_data, t1_data, th_data;
`endif

  logic [31:0] mdl [int];

  assign v0  = req_valid && (sel == 0);
  assign v1  = req_valid && (sel == 1);
  assign rr0 = rsp_ready_drv && (sel == 0);
  assign rr1 = rsp_ready_drv && (sel == 1);

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(q0_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_epoch(req_epoch), .rsp_valid(q0_valid),
    .rsp_ready(rr0), .rsp_rdata(q0_rdata), .rsp_err(q0_err), .rsp_epoch(q0_epoch)
`ifdef DMEM_TOHOST_EN
    , .tohost_valid(t0_valid), .tohost_data(t0_data)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(q1_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_epoch(req_epoch), .rsp_valid(q1_valid),
    .rsp_ready(rr1), .rsp_rdata(q1_rdata), .rsp_err(q1_err), .rsp_epoch(q1_epoch)
`ifdef DMEM_TOHOST_EN
    , .tohost_valid(t1_valid), .tohost_data(t1_data)
`endif
  );

  always_comb begin
    if (sel == 0) begin
      req_ready = q0_ready; rsp_valid = q0_valid; rsp_err = q0_err;
      rsp_rdata = q0_rdata; rsp_epoch = q0_epoch;
    end else begin
      req_ready = q1_ready; rsp_valid = q1_valid; rsp_err = q1_err;
      rsp_rdata = q1_rdata; rsp_epoch = q1_epoch;
    end
`ifdef DMEM_TOHOST_EN
    th_valid = (sel == 0) ? t0_valid : t1_valid;
    th_data  = (sel == 0) ? t0_data  : t1_data;
`endif
  end

  // One full request/response exchange checked against the memory model
  task automatic transact(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] ep, input int stall, input string name);
    bit          exp_err, hit, known, bad;
    logic [31:0] exp_rd, s_rd;
    logic [1:0]  s_ep;
    logic        s_err;
    int          exp_lat, lat, waitc, key;
    hit = 1'b0;
`ifdef DMEM_TOHOST_EN
    hit = (addr == TOHOST) && (op == OP_RD || op == OP_WR);
`endif
    exp_err = !(op == OP_RD || op == OP_WR) || (addr % 4 != 0) || (!hit && (addr / 4) >= DEPTH);
    key     = 0;
    if (!exp_err && !hit) key = sel * DEPTH + int'(addr / 4);
    exp_lat = (op == OP_RD && !exp_err) ? ((sel == 0) ? LAT0 : LAT1) : 1;
    known   = 1'b1;
    exp_rd  = 32'h0;
    if (op == OP_RD && !exp_err && !hit) begin
      if (mdl.exists(key)) exp_rd = mdl[key];
      else known = 1'b0;
    end

    req_op = op; req_addr = addr; req_wdata = wdata; req_epoch = ep; req_valid = 1'b1;
    waitc = 0;
    while (!req_ready && waitc < 20) begin @(posedge clk); #1; waitc++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: req_ready=%0b required 1", name, req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (op == OP_WR && !exp_err && !hit) mdl[key] = wdata;
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (rsp_valid !== 1'b1 || lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d (valid=%0b) required %0d", name, lat, rsp_valid, exp_lat);
      if (rsp_valid !== 1'b1) return;
    end
    checks++;
    if (rsp_err !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %0b required %0b", name, rsp_err, exp_err);
    end
    checks++;
    if (rsp_epoch !== ep) begin
      errors++;
      $display("FAIL %s epoch: got %0d required %0d", name, rsp_epoch, ep);
    end
    if (known) begin
      checks++;
      if (rsp_rdata !== exp_rd) begin
        errors++;
        $display("FAIL %s rdata: got %h required %h", name, rsp_rdata, exp_rd);
      end
    end
`ifdef DMEM_TOHOST_EN
    checks++;
    if (th_valid !== (hit && op == OP_WR) || (hit && op == OP_WR && th_data !== wdata)) begin
      errors++;
      $display("FAIL %s tohost: valid=%0b data=%h required valid=%0b data=%h", name, th_valid, th_data,
               (hit && op == OP_WR), wdata);
    end
`endif
    s_rd = rsp_rdata; s_ep = rsp_epoch; s_err = rsp_err;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      bad = (rsp_valid !== 1'b1) || (rsp_rdata !== s_rd) || (rsp_epoch !== s_ep) ||
            (rsp_err !== s_err) || (req_ready !== 1'b0);
`ifdef DMEM_TOHOST_EN
      bad = bad || (th_valid !== 1'b0);
`endif
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s stall cycle %0d: valid=%0b rdata=%h epoch=%0d ready=%0b required 1/%h/%0d/0",
                 name, i, rsp_valid, rsp_rdata, rsp_epoch, req_ready, s_rd, s_ep);
      end
    end
    rsp_ready_drv = 1'b1;
    @(posedge clk); #1;
    rsp_ready_drv = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s handshake: valid=%0b ready=%0b required 0/1", name, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #0;
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
          rsp_epoch !== EP_INV) begin
        errors++;
        $display("FAIL reset_values dut%0d: ready=%0b valid=%0b rdata=%h err=%0b epoch=%0d required 0/0/0/0/%0d",
                 s, req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_epoch, EP_INV);
      end
    end
    sel = 0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %0b required 0", req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge: got %0b required 1", req_ready);
    end
  endtask

  task automatic test_write_read;
    sel = 0;
    transact(OP_WR, 32'h10, 32'hDEADBEEF, EP_RED, 0, "wr_10");
    transact(OP_RD, 32'h10, 32'h0, EP_RED, 0, "rd_10");
  endtask

  task automatic test_errors;
    sel = 0;
    transact(OP_RD, 32'h12, 32'h0, EP_BLUE, 0, "rd_misaligned");
    transact(OP_RD, DEPTH * 4, 32'h0, EP_RED, 0, "rd_out_of_range");
    transact(OP_WR, 32'h12, 32'h12345678, EP_BLUE, 0, "wr_misaligned");
    transact(OP_WR, DEPTH * 4 + 16, 32'h87654321, EP_RED, 0, "wr_out_of_range");
    transact(OP_INV, 32'h10, 32'hCAFEF00D, EP_BLUE, 0, "op_invalid");
    transact(OP_RD, 32'h10, 32'h0, EP_BLUE, 0, "rd_10_after_errors");
  endtask

  task automatic test_stall;
    sel = 0;
    transact(OP_RD, 32'h10, 32'h0, EP_BLUE, 5, "rd_10_stall");
  endtask

  task automatic test_reset_mid;
    int seen;
    sel = 0;
    req_op = OP_RD; req_addr = 32'h10; req_epoch = EP_BLUE; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_epoch !== EP_INV) begin
      errors++;
      $display("FAIL reset_mid_async: valid=%0b ready=%0b epoch=%0d required 0/0/%0d",
               rsp_valid, req_ready, rsp_epoch, EP_INV);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_no_rsp: valid cycles=%0d ready=%0b required 0/1", seen, req_ready);
    end
    transact(OP_RD, 32'h10, 32'h0, EP_RED, 0, "rd_10_after_reset");
  endtask

  task automatic test_back_to_back;
    sel = 1;
    transact(OP_WR, 32'h20, 32'h5, EP_RED, 0, "b2b_wr_20");
    transact(OP_RD, 32'h20, 32'h0, EP_BLUE, 0, "b2b_rd_20");
    sel = 0;
  endtask

  task automatic test_random;
    logic [1:0]  op;
    logic [31:0] addr;
    int          r;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int w = 0; w < 8; w++) transact(OP_WR, 32'(w * 4 + 64), $urandom, 2'(w), 0, "rnd_fill");
    end
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 1);
      r   = $urandom_range(0, 9);
      op  = (r == 0) ? (($urandom_range(0, 1) == 0) ? OP_INV : 2'd3) : (r < 5) ? OP_WR : OP_RD;
      r   = $urandom_range(0, 7);
      addr = 32'($urandom_range(16, 23) * 4);
      if (r == 0) addr = addr + 32'($urandom_range(1, 3));
      if (r == 1) addr = 32'((DEPTH + $urandom_range(0, 100)) * 4);
      transact(op, addr, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 2), "rnd");
    end
    sel = 0;
  endtask

`ifdef DMEM_TOHOST_EN
  task automatic test_tohost;
    sel = 0;
    transact(OP_WR, TOHOST, 32'h1, EP_RED, 2, "tohost_wr");
    transact(OP_RD, TOHOST, 32'h0, EP_BLUE, 0, "tohost_rd");
    transact(OP_RD, 32'h10, 32'h0, EP_RED, 0, "rd_10_after_tohost");
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_errors();
    test_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef DMEM_TOHOST_EN
    test_tohost();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
